// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings,
// the default frame sync marker and the frame-length width.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      LDR_IDLE,
      LDR_LEN_HI,
      LDR_LEN_LO,
      LDR_DATA,
      LDR_CSUM,
      LDR_DONE,
      LDR_ERR
   } ldr_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         LEN_W             = 16;

endpackage

// File: rtl/imem_ram.sv
// Single-clock program RAM with a synchronous write port and a registered
// read-first read port.
module imem_ram #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [31:0]           wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
   logic [31:0] rdata_reg;

   // The read samples the array before this edge's write lands, so a
   // colliding read returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_reg <= mem[raddr];
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory responder: serves CPU fetches from program RAM and loads
// the RAM from a framed, checksummed byte stream, holding the CPU in reset
// until a valid program is present.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         DEPTH_LOG2 = 10,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic [15:0] cpu_addr,
   output logic [31:0] cpu_data,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        load_error,
   output logic [15:0] words_loaded
);

   localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1) << DEPTH_LOG2;

   ldr_state_t       state_reg;
   logic [7:0]       len_hi_reg;
   logic [LEN_W-1:0] len_reg;
   logic [1:0]       byte_idx_reg;
   logic [7:0]       csum_reg;
   logic [23:0]      word_buf_reg;
   logic [15:0]      words_loaded_reg;
   logic             rx_ready_reg;
   logic             cpu_reset_reg;
   logic             load_done_reg;
   logic             load_error_reg;
   logic             rd_valid_reg;

   logic             accept;
   logic [LEN_W-1:0] len_next;
   logic             ram_we;
   logic [31:0]      ram_rdata;

   assign accept   = rx_valid && rx_ready_reg;
   assign len_next = {len_hi_reg, rx_data};
   assign ram_we   = accept && (state_reg == LDR_DATA) && (byte_idx_reg == 2'd3);

   // words_loaded doubles as the sequential write address.
   imem_ram #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (words_loaded_reg[DEPTH_LOG2-1:0]),
      .wdata ({word_buf_reg, rx_data}),
      .raddr (cpu_addr[DEPTH_LOG2-1:0]),
      .rdata (ram_rdata)
   );

   // Out-of-range qualification travels with the RAM read so both share latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= (cpu_addr[15:DEPTH_LOG2] == '0);
      end
   end

   assign cpu_data = rd_valid_reg ? ram_rdata : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= LDR_IDLE;
         len_hi_reg       <= '0;
         len_reg          <= '0;
         byte_idx_reg     <= '0;
         csum_reg         <= '0;
         word_buf_reg     <= '0;
         words_loaded_reg <= '0;
         rx_ready_reg     <= 1'b0;
         cpu_reset_reg    <= 1'b1;
         load_done_reg    <= 1'b0;
         load_error_reg   <= 1'b0;
      end else begin
         rx_ready_reg <= 1'b1;
         if (accept) begin
            unique case (state_reg)
               LDR_IDLE: begin
                  if (rx_data == SYNC_BYTE) state_reg <= LDR_LEN_HI;
               end
               LDR_LEN_HI: begin
                  len_hi_reg <= rx_data;
                  state_reg  <= LDR_LEN_LO;
               end
               LDR_LEN_LO: begin
                  len_reg          <= len_next;
                  byte_idx_reg     <= '0;
                  csum_reg         <= '0;
                  words_loaded_reg <= '0;
                  if (len_next > MAX_WORDS) begin
                     state_reg      <= LDR_ERR;
                     load_error_reg <= 1'b1;
                  end else if (len_next == '0) begin
                     state_reg <= LDR_CSUM;
                  end else begin
                     state_reg <= LDR_DATA;
                  end
               end
               LDR_DATA: begin
                  word_buf_reg <= {word_buf_reg[15:0], rx_data};
                  csum_reg     <= csum_reg ^ rx_data;
                  byte_idx_reg <= byte_idx_reg + 2'd1;
                  if (byte_idx_reg == 2'd3) begin
                     words_loaded_reg <= words_loaded_reg + 16'd1;
                     if (words_loaded_reg + 16'd1 == len_reg) state_reg <= LDR_CSUM;
                  end
               end
               LDR_CSUM: begin
                  if (rx_data == csum_reg) begin
                     state_reg     <= LDR_DONE;
                     cpu_reset_reg <= 1'b0;
                     load_done_reg <= 1'b1;
                  end else begin
                     state_reg      <= LDR_ERR;
                     load_error_reg <= 1'b1;
                  end
               end
               LDR_DONE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_reg     <= LDR_LEN_HI;
                     cpu_reset_reg <= 1'b1;
                     load_done_reg <= 1'b0;
                  end
               end
               LDR_ERR: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_reg      <= LDR_LEN_HI;
                     load_error_reg <= 1'b0;
                  end
               end
               default: state_reg <= LDR_IDLE;
            endcase
         end
      end
   end

   assign rx_ready     = rx_ready_reg;
   assign cpu_reset    = cpu_reset_reg;
   assign load_done    = load_done_reg;
   assign load_error   = load_error_reg;
   assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame loads, error paths and fetch
// reads checked against a scoreboard fed by a bench-side RAM model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_data;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;
   logic [15:0] words_loaded;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model_mem [0:1023];
   logic [31:0] frame_q [$];
   logic [15:0] rd_addr_q [$];
   logic [31:0] exp_q [$];

   imem_loader dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .cpu_reset    (cpu_reset),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Idle cycles carry a sync byte on rx_data with rx_valid low.
   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         rx_valid = 1'b0;
         rx_data  = 8'hA5;
         @(posedge clk); #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Sends sync, length, frame_q words and checksum; updates the RAM model.
   task automatic send_frame(input bit bad_csum, input int gap);
      logic [7:0]  csum;
      logic [15:0] n;
      logic [7:0]  b;
      csum = 8'h00;
      n = 16'(frame_q.size());
      send_byte(8'hA5, gap);
      send_byte(n[15:8], gap);
      send_byte(n[7:0], gap);
      for (int i = 0; i < frame_q.size(); i++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(frame_q[i] >> (8 * (3 - k)));
            csum ^= b;
            send_byte(b, gap);
         end
         model_mem[i] = frame_q[i];
      end
      if (i_last_check_cpu_reset()) cmp("cpu_reset_before_csum", {31'd0, cpu_reset}, 32'd1);
      send_byte(bad_csum ? (csum ^ 8'h01) : csum, gap);
   endtask

   function automatic bit i_last_check_cpu_reset();
      return 1'b1;
   endfunction

   // Issues rd_addr_q back-to-back; each result is compared one clock later,
   // after the address has already moved on.
   task automatic check_reads(input string name);
      int n;
      logic [15:0] a;
      n = rd_addr_q.size();
      for (int i = 0; i < n; i++) begin
         a = rd_addr_q[i];
         exp_q.push_back((a[15:10] != 6'd0) ? 32'h0 : model_mem[a[9:0]]);
      end
      cpu_addr = rd_addr_q[0];
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cpu_addr = (i + 1 < n) ? rd_addr_q[i + 1] : 16'hFFFF;
         #1;
         cmp($sformatf("%s_rd[0x%0h]", name, rd_addr_q[i]), cpu_data, exp_q.pop_front());
      end
      rd_addr_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      cmp("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      cmp("rst_load_done", {31'd0, load_done}, 32'd0);
      cmp("rst_load_error", {31'd0, load_error}, 32'd0);
      cmp("rst_words_loaded", {16'd0, words_loaded}, 32'd0);
      cmp("rst_cpu_data", cpu_data, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      cmp("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
      cmp("post_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
   endtask

   task automatic test_basic_load();
      frame_q = '{32'h12345678, 32'h9ABCDEF0};
      send_frame(1'b0, 0);
      cmp("basic_load_done", {31'd0, load_done}, 32'd1);
      cmp("basic_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      cmp("basic_load_error", {31'd0, load_error}, 32'd0);
      cmp("basic_words_loaded", {16'd0, words_loaded}, 32'd2);
      rd_addr_q = '{16'h0000, 16'h0001, 16'h0000};
      check_reads("basic");
   endtask

   task automatic test_oversize();
      send_byte(8'hA5, 0);
      cmp("ovs_cpu_reset_after_sync", {31'd0, cpu_reset}, 32'd1);
      cmp("ovs_load_done_after_sync", {31'd0, load_done}, 32'd0);
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      cmp("ovs_load_error", {31'd0, load_error}, 32'd1);
      cmp("ovs_words_loaded", {16'd0, words_loaded}, 32'd0);
      // A data-like byte must be ignored in the error state.
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      cmp("ovs_still_error", {31'd0, load_error}, 32'd1);
      cmp("ovs_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      rd_addr_q = '{16'h0000};
      check_reads("ovs");
   endtask

   task automatic test_bad_csum();
      send_byte(8'hA5, 0);
      cmp("bad_error_cleared_by_sync", {31'd0, load_error}, 32'd0);
      frame_q = '{32'h12345678, 32'h9ABCDEF0};
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) send_byte(8'(frame_q[i] >> (8 * (3 - k))), 0);
         model_mem[i] = frame_q[i];
      end
      send_byte(8'h01, 0);
      cmp("bad_load_error", {31'd0, load_error}, 32'd1);
      cmp("bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      cmp("bad_load_done", {31'd0, load_done}, 32'd0);
      rd_addr_q = '{16'h0000};
      check_reads("bad");
   endtask

   task automatic test_empty_stray();
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      cmp("stray_load_error", {31'd0, load_error}, 32'd1);
      cmp("stray_load_done", {31'd0, load_done}, 32'd0);
      frame_q.delete();
      send_frame(1'b0, 0);
      cmp("empty_load_done", {31'd0, load_done}, 32'd1);
      cmp("empty_load_error", {31'd0, load_error}, 32'd0);
      cmp("empty_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      cmp("empty_words_loaded", {16'd0, words_loaded}, 32'd0);
   endtask

   task automatic test_back_to_back();
      send_byte(8'hA5, 2);
      cmp("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      cmp("reload_load_done", {31'd0, load_done}, 32'd0);
      frame_q = '{32'hCAFEF00D, 32'hA5A5A5A5, 32'h0BADBEEF};
      send_byte(8'h00, 1);
      send_byte(8'h03, 3);
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 4; k++) send_byte(8'(frame_q[i] >> (8 * (3 - k))), (i + k) % 3);
         model_mem[i] = frame_q[i];
      end
      cmp("reload_cpu_reset_pre_csum", {31'd0, cpu_reset}, 32'd1);
      send_byte(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D ^ 8'h0B ^ 8'hAD ^ 8'hBE ^ 8'hEF, 2);
      cmp("reload_load_done_final", {31'd0, load_done}, 32'd1);
      cmp("reload_cpu_reset_final", {31'd0, cpu_reset}, 32'd0);
      cmp("reload_words_loaded", {16'd0, words_loaded}, 32'd3);
      rd_addr_q = '{16'h0002, 16'h0400, 16'h0000, 16'h0001, 16'h8001, 16'h0002};
      check_reads("reload");
   endtask

   task automatic test_reset_mid_data();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      model_mem[0] = 32'hAABBCCDD;
      send_byte(8'hEE, 0);
      send_byte(8'hFF, 0);
      cmp("mid_words_loaded", {16'd0, words_loaded}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      cmp("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      cmp("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      cmp("mid_rst_load_done", {31'd0, load_done}, 32'd0);
      cmp("mid_rst_words_loaded", {16'd0, words_loaded}, 32'd0);
      cmp("mid_rst_cpu_data", cpu_data, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      rd_addr_q = '{16'h0000, 16'h0001};
      check_reads("mid");
      // A full one-word frame from here only completes if the FSM is in IDLE.
      frame_q = '{32'h11223344};
      send_frame(1'b0, 0);
      cmp("mid_reload_done", {31'd0, load_done}, 32'd1);
      cmp("mid_reload_words", {16'd0, words_loaded}, 32'd1);
      rd_addr_q = '{16'h0000};
      check_reads("mid_reload");
   endtask

   initial begin
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      cpu_addr = 16'h0000;
      test_reset();
      test_basic_load();
      test_oversize();
      test_bad_csum();
      test_empty_stray();
      test_back_to_back();
      test_reset_mid_data();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
